board_color_renderer: RTL and testbench
=======================================

Name: board_color_renderer

Overview:
- Parametrised, pipelined successor to the Connect-Four cell colour lookup, generalised to any ROWS x COLS board.
- Maps the VGA-side cell coordinate to a 2-bit colour code with fixed 2-cycle latency.
- Adds frame-timed blinking of winning tokens and a falling-token drop animation under a start/busy/done handshake.
- Sits between the game-state registers and the sprite/palette stage of the VGA path.

Parameters:
- ROWS, 6, board rows; row 0 is the top row.
- COLS, 7, board columns.
- FALL_FRAMES, 4, frame_tick pulses per row step of a falling token (>=1).
- BLINK_FRAMES, 15, frame_tick pulses per blink half-period (>=1).

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- row  in  11  cell row of the current pixel.
- col  in  11  cell column of the current pixel.
- cell_valid  in  1  row/col are meaningful this cycle.
- frame_tick  in  1  one-cycle pulse once per video frame.
- winner_tokens  in  ROWS*COLS  winning cells; bit index r*COLS+c.
- color_p0  in  ROWS*COLS  cells owned by player 0.
- color_p1  in  ROWS*COLS  cells owned by player 1.
- blink_en  in  1  enable blinking of winning cells.
- drop_start  in  1  request a drop animation (pulse).
- drop_col  in  11  column of the dropped token.
- drop_row  in  11  landing row of the dropped token.
- drop_player  in  1  0 = player 0, 1 = player 1.
- color  out  2  00 empty, 01 p0, 10 p1, 11 winner highlight.
- color_valid  out  1  cell_valid delayed 2 cycles.
- drop_busy  out  1  animation in progress.
- drop_done  out  1  one-cycle pulse when the token lands.
- drop_err  out  1  one-cycle pulse when drop_start is rejected.

Behaviour:
- Reset (synchronous, active-high): color=00, color_valid=0, drop_busy=0, drop_done=0, drop_err=0, FSM=IDLE, blink_phase=1, all counters=0. Reset mid-animation aborts it immediately; no drop_done is issued.
- Pipeline: stage 1 registers the range check (row<ROWS && col<COLS), the bit lookups, and the anim/target match flags. Stage 2 registers color and color_valid. Fixed latency is 2; there is no stall.
- Colour priority in stage 2, first match wins:
  - out of range -> 00.
  - FSM=FALL and (row,col)==(anim_row,drop_col) -> player colour (01/10).
  - FSM=FALL and (row,col)==(drop_row,drop_col) -> 00; the target cell is masked until landing.
  - winner bit set: blink_phase=1 -> 11; otherwise the owner colour (p0 has priority).
  - p0 bit -> 01; p1 bit -> 10; otherwise 00.
- Drop FSM has three states: IDLE, FALL, DONE.
- IDLE:
  - On drop_start with drop_col<COLS and drop_row<ROWS: latch col, row and player; anim_row=0; fall_cnt=0; go to FALL.
  - On an out-of-range request: pulse drop_err the next cycle and stay in IDLE.
- FALL:
  - Each frame_tick increments fall_cnt.
  - When fall_cnt reaches FALL_FRAMES-1 on a tick:
    - if anim_row==latched row -> go to DONE;
    - else anim_row+1 and fall_cnt=0.
- DONE: drop_done=1 for exactly one cycle, then IDLE.
- drop_busy=1 in FALL and DONE.
- A landing at row R takes exactly (R+1)*FALL_FRAMES frame_ticks after acceptance.
- drop_start while busy is ignored: no err, no restart.
- A frame_tick in the same cycle as acceptance is not counted.
- Board vectors already contain the dropped token; the renderer only masks and animates it.
- Blink:
  - While blink_en=1, blink_cnt counts frame_ticks; at BLINK_FRAMES-1 on a tick, blink_phase toggles and blink_cnt=0.
  - While blink_en=0: blink_phase=1 and blink_cnt=0 (solid highlight).
  - Rising blink_en starts from phase 1.
- Bit index is computed as r*COLS+c in a width sized by $clog2(ROWS*COLS). It is only evaluated for in-range coordinates; no out-of-range vector access.

Decomposition:
- Package board_pkg:
  - color codes COLOR_EMPTY=2'b00, COLOR_P0=2'b01, COLOR_P1=2'b10, COLOR_WIN=2'b11;
  - typedef drop_state_t {IDLE, FALL, DONE};
  - function cell_index(r, c, cols).
- One sub-module, frame_divider (parameter N; inputs clk, reset, en, frame_tick; output a terminal-count pulse). It is instantiated for the blink timer; the fall counter also uses it, with its count cleared on acceptance.

Test Plan:
- ROWS=6, COLS=7; color_p0 bit 0 set, row=0, col=0, cell_valid=1 -> color=01 and color_valid=1 exactly 2 cycles later; row=6 or col=7 -> 00.
- winner bit 41 and p1 bit 41 set, blink_en=1, BLINK_FRAMES=3 -> color at (5,6) is 11 for 3 ticks, 10 for 3 ticks, then repeats; blink_en=0 -> solid 11.
- FALL_FRAMES=2, drop_col=3, drop_row=5, player 1 -> (0,3) shows 10 and (5,3) shows 00; anim moves down one row every 2 ticks; drop_done pulses after 12 ticks; drop_busy drops the following cycle.
- drop_start with drop_row=6 -> drop_err pulse 1 cycle, drop_busy stays 0; a second drop_start mid-FALL -> ignored, landing time unchanged.
- reset asserted during FALL at anim_row=2 -> next cycle drop_busy=0, color=00, color_valid=0, no drop_done; a new drop is accepted immediately after reset.
- drop_start coincident with frame_tick in IDLE -> landing at row 0 takes exactly FALL_FRAMES further ticks.

Source files
------------

// File: rtl/board_pkg.sv
// Shared colour codes, drop-animation state encoding and board indexing helper
// for the board colour renderer.
package board_pkg;

    localparam int COORD_W = 11;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_EMPTY = 2'b00;
    localparam color_t COLOR_P0    = 2'b01;
    localparam color_t COLOR_P1    = 2'b10;
    localparam color_t COLOR_WIN   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FALL = 2'b01,
        DONE = 2'b10
    } drop_state_t;

    // Row-major flat index of a board cell; callers only use it for in-range cells.
    function automatic int unsigned cell_index(input int unsigned r,
                                               input int unsigned c,
                                               input int unsigned cols);
        return (r * cols) + c;
    endfunction

endpackage

// File: rtl/board_color_renderer_frame_divider.sv
// Counts frame_tick pulses while enabled and flags the tick that completes a
// group of N; disabling the divider clears its count.
module frame_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic frame_tick,
    output logic tc
);
    import board_pkg::*;

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and terminal-count pulse.
    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (!en) begin
            cnt_d = {CW{1'b0}};
        end else if (frame_tick) begin
            if (cnt_q == LAST) begin
                cnt_d = {CW{1'b0}};
                tc    = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/board_color_renderer.sv
// Two-stage pixel-to-colour lookup for a ROWS x COLS board, with blinking
// winner highlight and a frame-timed falling-token animation.
module board_color_renderer #(
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int FALL_FRAMES  = 4,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          row,
    input  logic [10:0]          col,
    input  logic                 cell_valid,
    input  logic                 frame_tick,
    input  logic [ROWS*COLS-1:0] winner_tokens,
    input  logic [ROWS*COLS-1:0] color_p0,
    input  logic [ROWS*COLS-1:0] color_p1,
    input  logic                 blink_en,
    input  logic                 drop_start,
    input  logic [10:0]          drop_col,
    input  logic [10:0]          drop_row,
    input  logic                 drop_player,
    output logic [1:0]           color,
    output logic                 color_valid,
    output logic                 drop_busy,
    output logic                 drop_done,
    output logic                 drop_err
);
    import board_pkg::*;

    localparam int                 CELLS  = ROWS * COLS;
    localparam int                 IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(ROWS);
    localparam logic [COORD_W-1:0] COLS_C = COORD_W'(COLS);

    drop_state_t        state_q, state_d;
    logic [COORD_W-1:0] tgt_col_q, tgt_col_d;
    logic [COORD_W-1:0] tgt_row_q, tgt_row_d;
    logic [COORD_W-1:0] anim_row_q, anim_row_d;
    logic               player_q, player_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               blink_phase_q, blink_phase_d;
    logic               fall_tc_s, blink_tc_s, fall_en_s, in_range_s;
    logic [IDX_W-1:0]   idx_s;

    logic s1_valid_q, s1_valid_d, s1_in_range_q, s1_in_range_d;
    logic s1_win_q, s1_win_d, s1_p0_q, s1_p0_d, s1_p1_q, s1_p1_d;
    logic s1_anim_hit_q, s1_anim_hit_d, s1_tgt_hit_q, s1_tgt_hit_d;
    color_t color_q, color_d;
    logic   color_valid_q, color_valid_d;

    assign fall_en_s = (state_q == FALL);

    frame_divider #(.N(FALL_FRAMES)) u_fall_div (
        .clk(clk), .reset(reset), .en(fall_en_s), .frame_tick(frame_tick), .tc(fall_tc_s)
    );

    frame_divider #(.N(BLINK_FRAMES)) u_blink_div (
        .clk(clk), .reset(reset), .en(blink_en), .frame_tick(frame_tick), .tc(blink_tc_s)
    );

    // Drop FSM: accept/reject requests, step the falling token, pulse on landing.
    always_comb begin
        state_d    = state_q;
        tgt_col_d  = tgt_col_q;
        tgt_row_d  = tgt_row_q;
        anim_row_d = anim_row_q;
        player_d   = player_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (drop_start) begin
                    if ((drop_col < COLS_C) && (drop_row < ROWS_C)) begin
                        tgt_col_d  = drop_col;
                        tgt_row_d  = drop_row;
                        player_d   = drop_player;
                        anim_row_d = {COORD_W{1'b0}};
                        state_d    = FALL;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FALL: begin
                if (fall_tc_s) begin
                    if (anim_row_q == tgt_row_q) begin
                        state_d = DONE;
                    end else begin
                        anim_row_d = anim_row_q + 11'd1;
                    end
                end else begin
                    state_d = FALL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Blink phase: solid while disabled, toggles every BLINK_FRAMES ticks otherwise.
    always_comb begin
        if (!blink_en) begin
            blink_phase_d = 1'b1;
        end else if (blink_tc_s) begin
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_phase_d = blink_phase_q;
        end
    end

    // Stage 1: range check, board lookups (in-range only) and animation matches.
    always_comb begin
        in_range_s    = (row < ROWS_C) && (col < COLS_C);
        idx_s         = {IDX_W{1'b0}};
        s1_valid_d    = cell_valid;
        s1_in_range_d = in_range_s;
        if (in_range_s) begin
            idx_s    = IDX_W'(cell_index(32'(row), 32'(col), 32'(COLS)));
            s1_win_d = winner_tokens[idx_s];
            s1_p0_d  = color_p0[idx_s];
            s1_p1_d  = color_p1[idx_s];
        end else begin
            s1_win_d = 1'b0;
            s1_p0_d  = 1'b0;
            s1_p1_d  = 1'b0;
        end
        s1_anim_hit_d = fall_en_s && (row == anim_row_q) && (col == tgt_col_q);
        s1_tgt_hit_d  = fall_en_s && (row == tgt_row_q) && (col == tgt_col_q);
    end

    // Stage 2: colour priority resolution.
    always_comb begin
        color_d       = COLOR_EMPTY;
        color_valid_d = s1_valid_q;
        if (!s1_in_range_q) begin
            color_d = COLOR_EMPTY;
        end else if (s1_anim_hit_q) begin
            color_d = player_q ? COLOR_P1 : COLOR_P0;
        end else if (s1_tgt_hit_q) begin
            color_d = COLOR_EMPTY;
        end else if (s1_win_q && blink_phase_q) begin
            color_d = COLOR_WIN;
        end else if (s1_p0_q) begin
            color_d = COLOR_P0;
        end else if (s1_p1_q) begin
            color_d = COLOR_P1;
        end else begin
            color_d = COLOR_EMPTY;
        end
    end

    // All state and pipeline registers; reset aborts any animation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tgt_col_q     <= {COORD_W{1'b0}};
            tgt_row_q     <= {COORD_W{1'b0}};
            anim_row_q    <= {COORD_W{1'b0}};
            player_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            blink_phase_q <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_win_q      <= 1'b0;
            s1_p0_q       <= 1'b0;
            s1_p1_q       <= 1'b0;
            s1_anim_hit_q <= 1'b0;
            s1_tgt_hit_q  <= 1'b0;
            color_q       <= COLOR_EMPTY;
            color_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_col_q     <= tgt_col_d;
            tgt_row_q     <= tgt_row_d;
            anim_row_q    <= anim_row_d;
            player_q      <= player_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            blink_phase_q <= blink_phase_d;
            s1_valid_q    <= s1_valid_d;
            s1_in_range_q <= s1_in_range_d;
            s1_win_q      <= s1_win_d;
            s1_p0_q       <= s1_p0_d;
            s1_p1_q       <= s1_p1_d;
            s1_anim_hit_q <= s1_anim_hit_d;
            s1_tgt_hit_q  <= s1_tgt_hit_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign drop_busy   = busy_q;
    assign drop_done   = done_q;
    assign drop_err    = err_q;

endmodule

// File: tb/tb_board_color_renderer.sv
// Scoreboard bench for board_color_renderer: pixel requests queue their expected
// colour, a negedge monitor compares whatever the DUT presents.
module tb_board_color_renderer;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int FF    = 2;
    localparam int BF    = 3;
    localparam int CELLS = ROWS * COLS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [10:0]      row = 11'd0, col = 11'd0, drop_col = 11'd0, drop_row = 11'd0;
    logic             cell_valid = 1'b0, frame_tick = 1'b0, blink_en = 1'b0;
    logic             drop_start = 1'b0, drop_player = 1'b0;
    logic [CELLS-1:0] winner_tokens = '0, color_p0 = '0, color_p1 = '0;
    logic [1:0]       color;
    logic             color_valid, drop_busy, drop_done, drop_err;

    int checks = 0, errors = 0, cyc_n = 0, tick_cnt = 0;
    int done_cnt = 0, err_cnt = 0, done_at_tick = -1;
    int base_tick, base_done;
    logic prev_done = 1'b0;
    logic [1:0] exp_q[$];
    int         iss_q[$];
    logic [1:0] mon_e;
    int         mon_i;

    board_color_renderer #(.ROWS(ROWS), .COLS(COLS), .FALL_FRAMES(FF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .cell_valid(cell_valid),
        .frame_tick(frame_tick), .winner_tokens(winner_tokens), .color_p0(color_p0),
        .color_p1(color_p1), .blink_en(blink_en), .drop_start(drop_start),
        .drop_col(drop_col), .drop_row(drop_row), .drop_player(drop_player),
        .color(color), .color_valid(color_valid), .drop_busy(drop_busy),
        .drop_done(drop_done), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        tick_cnt++;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic pixel(input int r, input int c, input logic [1:0] e);
        row        = 11'(r);
        col        = 11'(c);
        cell_valid = 1'b1;
        exp_q.push_back(e);
        iss_q.push_back(cyc_n);
        cyc();
        cell_valid = 1'b0;
        cyc();
        cyc();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_timeout: (%0d,%0d) no color_valid, expected %0d", r, c, e);
            exp_q.delete();
            iss_q.delete();
        end
    endtask

    // Monitor: colour scoreboard, latency, drop pulse bookkeeping.
    always @(negedge clk) begin
        if (color_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL color_unexpected: color %0d with nothing pending", color);
            end else begin
                mon_e = exp_q.pop_front();
                mon_i = iss_q.pop_front();
                chk_int("color", int'(color), int'(mon_e));
                chk_int("latency", cyc_n - mon_i, 2);
            end
        end
        if (prev_done) chk_bit("busy_after_done", drop_busy, 1'b0);
        if (drop_done === 1'b1) begin
            done_cnt++;
            done_at_tick = tick_cnt;
        end
        if (drop_err === 1'b1) err_cnt++;
        prev_done = (drop_done === 1'b1);
    end

    initial begin
        repeat (3) cyc();
        chk_int("rst_color", int'(color), 0);
        chk_bit("rst_valid", color_valid, 1'b0);
        chk_bit("rst_busy", drop_busy, 1'b0);
        chk_bit("rst_done", drop_done, 1'b0);
        chk_bit("rst_err", drop_err, 1'b0);
        reset = 1'b0;
        cyc();

        // Basic lookup and range checks.
        color_p0[0] = 1'b1;
        pixel(0, 0, 2'b01);
        pixel(6, 0, 2'b00);
        pixel(0, 7, 2'b00);
        pixel(2047, 0, 2'b00);
        pixel(5, 6, 2'b00);
        color_p1[9] = 1'b1;
        pixel(1, 2, 2'b10);
        color_p0[9] = 1'b1;
        pixel(1, 2, 2'b01);
        winner_tokens[9] = 1'b1;
        pixel(1, 2, 2'b11);

        // Blinking winner at (5,6).
        color_p0 = '0; color_p1 = '0; winner_tokens = '0;
        winner_tokens[41] = 1'b1;
        color_p1[41] = 1'b1;
        blink_en = 1'b1;
        cyc();
        for (int t = 0; t < 9; t++) begin
            pixel(5, 6, (((t / 3) % 2) == 0) ? 2'b11 : 2'b10);
            tick();
        end
        pixel(5, 6, 2'b10);
        blink_en = 1'b0;
        cyc();
        pixel(5, 6, 2'b11);
        tick();
        pixel(5, 6, 2'b11);
        blink_en = 1'b1;
        cyc();
        pixel(5, 6, 2'b11);
        tick(); tick();
        pixel(5, 6, 2'b11);
        tick();
        pixel(5, 6, 2'b10);
        blink_en = 1'b0;
        winner_tokens = '0; color_p1 = '0;

        // Rejected requests.
        drop_row = 11'd6; drop_col = 11'd3; drop_start = 1'b1;
        cyc();
        drop_start = 1'b0;
        chk_bit("err_row_pulse", drop_err, 1'b1);
        chk_bit("err_row_busy", drop_busy, 1'b0);
        cyc();
        chk_bit("err_row_clear", drop_err, 1'b0);
        drop_row = 11'd0; drop_col = 11'd7; drop_start = 1'b1;
        cyc();
        drop_start = 1'b0;
        chk_bit("err_col_pulse", drop_err, 1'b1);
        chk_bit("err_col_busy", drop_busy, 1'b0);
        cyc();
        chk_int("err_count", err_cnt, 2);

        // Player 1 drop into column 3 landing on row 5.
        color_p1[38] = 1'b1;
        drop_col = 11'd3; drop_row = 11'd5; drop_player = 1'b1; drop_start = 1'b1;
        cyc();
        drop_start = 1'b0;
        chk_bit("drop_busy_start", drop_busy, 1'b1);
        base_tick = tick_cnt;
        base_done = done_cnt;
        for (int k = 0; k < 6; k++) begin
            pixel(k, 3, 2'b10);
            pixel(5, 3, (k == 5) ? 2'b10 : 2'b00);
            if (k > 0) pixel(k - 1, 3, 2'b00);
            if (k == 2) begin
                drop_col = 11'd0; drop_row = 11'd0; drop_player = 1'b0; drop_start = 1'b1;
                cyc();
                drop_start = 1'b0;
                chk_bit("ignored_start_busy", drop_busy, 1'b1);
            end
            tick();
            if (k == 5) chk_int("no_early_done", done_cnt, base_done);
            tick();
        end
        chk_int("drop_done_count", done_cnt, base_done + 1);
        chk_int("drop_land_ticks", done_at_tick - base_tick, 12);
        chk_bit("drop_busy_end", drop_busy, 1'b0);
        chk_int("no_err_on_busy", err_cnt, 2);
        pixel(5, 3, 2'b10);

        // Reset mid-fall, then an immediate drop coincident with a tick.
        color_p1 = '0; color_p0 = '0;
        color_p0[37] = 1'b1;
        drop_col = 11'd2; drop_row = 11'd5; drop_player = 1'b0; drop_start = 1'b1;
        cyc();
        drop_start = 1'b0;
        repeat (4) tick();
        pixel(2, 2, 2'b01);
        base_done = done_cnt;
        row = 11'd2; col = 11'd2; cell_valid = 1'b1; reset = 1'b1;
        cyc();
        cell_valid = 1'b0;
        chk_bit("rst_mid_busy", drop_busy, 1'b0);
        chk_int("rst_mid_color", int'(color), 0);
        chk_bit("rst_mid_valid", color_valid, 1'b0);
        reset = 1'b0;
        drop_col = 11'd4; drop_row = 11'd0; drop_player = 1'b1;
        drop_start = 1'b1; frame_tick = 1'b1;
        cyc();
        drop_start = 1'b0; frame_tick = 1'b0;
        chk_int("rst_no_done", done_cnt, base_done);
        chk_bit("post_rst_accept", drop_busy, 1'b1);
        base_tick = tick_cnt;
        pixel(0, 4, 2'b10);
        tick();
        chk_int("coincident_not_counted", done_cnt, base_done);
        tick();
        chk_int("coincident_done", done_cnt, base_done + 1);
        chk_int("coincident_ticks", done_at_tick - base_tick, FF);

        repeat (3) cyc();
        chk_int("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
